// File: rtl/gpio_cfg_pkg.sv
// Shared definitions for the GPIO serial configuration chain.
//   GPIO_BITS : width of one pad configuration word
//   state_t   : transmitter sequencing states
//   PAD_MODE_*: named pad-mode words used for pad defaults and the config store
package gpio_cfg_pkg;

    localparam int unsigned GPIO_BITS = 13;

    typedef logic [GPIO_BITS-1:0] pad_cfg_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        SETTLE
    } state_t;

    localparam pad_cfg_t PAD_MODE_MGMT_STD_INPUT_NOPULL  = 13'h0403;
    localparam pad_cfg_t PAD_MODE_MGMT_STD_OUTPUT        = 13'h1809;
    localparam pad_cfg_t PAD_MODE_MGMT_STD_BIDIRECTIONAL = 13'h1801;
    localparam pad_cfg_t PAD_MODE_MGMT_STD_ANALOG        = 13'h1803;
    localparam pad_cfg_t PAD_MODE_USER_STD_INPUT_NOPULL  = 13'h0402;
    localparam pad_cfg_t PAD_MODE_USER_STD_OUTPUT        = 13'h1808;
    localparam pad_cfg_t PAD_MODE_USER_STD_BIDIRECTIONAL = 13'h1800;

endpackage

// File: rtl/gpio_serial_tick.sv
// Phase timer for the serial chain: pulses phase_end on the last cycle of
// every CLK_DIV-cycle phase.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : hold the count at zero (untimed states)
//   phase_end : high during the final cycle of a phase
module gpio_serial_tick
    import gpio_cfg_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic phase_end
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);

    logic [CNT_W-1:0] cnt;

    assign phase_end = (cnt == CNT_W'(CLK_DIV - 1));

    // Wrapping on phase_end means every timed state starts from zero, since
    // timed states only change on phase_end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || phase_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gpio_serial_cfg_tx.sv
// Transmitter end of the GPIO serial configuration chain. Reads one word per
// pad from a synchronous config store (pad NUM_GPIO-1 first), shifts the chain
// out MSB first on serial_clock/serial_data, then strobes serial_load.
//   wb_clk_i, wb_rst_i : clock, asynchronous active-high reset
//   start              : single-cycle transfer request (ignored while busy)
//   cfg_addr, cfg_data : config store address / read data (1-cycle latency)
//   busy, done         : transfer in progress / one-cycle completion pulse
//   serial_clock/data/load : chain shift clock, data, latch strobe
module gpio_serial_cfg_tx #(
    parameter int unsigned GPIO_BITS = gpio_cfg_pkg::GPIO_BITS,
    parameter int unsigned NUM_GPIO  = 19,
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned ADDR_W    = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 start,
    output logic [ADDR_W-1:0]    cfg_addr,
    input  logic [GPIO_BITS-1:0] cfg_data,
    output logic                 busy,
    output logic                 done,
    output logic                 serial_clock,
    output logic                 serial_data,
    output logic                 serial_load
);

    import gpio_cfg_pkg::*;

    localparam int unsigned BCNT_W = (GPIO_BITS > 2) ? $clog2(GPIO_BITS) : 1;

    state_t                state;
    logic [BCNT_W-1:0]     bit_cnt;
    // The MSB goes straight to serial_data at capture, so only the remaining
    // bits are held here.
    logic [GPIO_BITS-2:0]  shreg;
    logic                  tick_clear;
    logic                  phase_end;

    assign tick_clear = (state inside {IDLE, LOAD_A, LOAD_B});

    gpio_serial_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .clear     (tick_clear),
        .phase_end (phase_end)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            serial_clock <= 1'b0;
            serial_data  <= 1'b0;
            serial_load  <= 1'b0;
            cfg_addr     <= ADDR_W'(NUM_GPIO - 1);
            shreg        <= '0;
            bit_cnt      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        state <= LOAD_A;
                    end
                end
                LOAD_A: begin
                    state <= LOAD_B;
                end
                LOAD_B: begin
                    shreg       <= cfg_data[GPIO_BITS-2:0];
                    serial_data <= cfg_data[GPIO_BITS-1];
                    bit_cnt     <= BCNT_W'(GPIO_BITS - 1);
                    state       <= SHIFT_LO;
                end
                SHIFT_LO: begin
                    if (phase_end) begin
                        serial_clock <= 1'b1;
                        state        <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (phase_end) begin
                        serial_clock <= 1'b0;
                        if (bit_cnt != '0) begin
                            bit_cnt     <= bit_cnt - 1'b1;
                            serial_data <= shreg[GPIO_BITS-2];
                            shreg       <= shreg << 1;
                            state       <= SHIFT_LO;
                        end else if (cfg_addr != '0) begin
                            cfg_addr <= cfg_addr - 1'b1;
                            state    <= LOAD_A;
                        end else begin
                            serial_data <= 1'b0;
                            serial_load <= 1'b1;
                            state       <= LATCH;
                        end
                    end
                end
                LATCH: begin
                    if (phase_end) begin
                        serial_load <= 1'b0;
                        state       <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (phase_end) begin
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        cfg_addr <= ADDR_W'(NUM_GPIO - 1);
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/gpio_serial_cfg_tx.md
Name: gpio_serial_cfg_tx

Overview:
Transmitter end of the GPIO serial configuration chain. On a start request it reads one GPIO_BITS-wide configuration word per pad from a synchronous config store. Each word is a pad default, or a value overridden later. It shifts the whole chain out on serial_clock/serial_data, then pulses serial_load so every pad's control block latches its word together. It sits in housekeeping and drives the chain consumed by the per-pad control blocks.

Parameters:
GPIO_BITS, 13, width of one pad configuration word
NUM_GPIO, 19, number of pads on the chain
CLK_DIV, 4, wb_clk_i cycles per serial_clock phase (low phase and high phase each); legal range is 1 or more
ADDR_W, $clog2(NUM_GPIO) with a floor of 1, width of cfg_addr

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to transfer the full chain
cfg_addr  out  ADDR_W  pad index being read from the config store
cfg_data  in  GPIO_BITS  config store read data; valid one cycle after cfg_addr changes
busy  out  1  transfer in progress
done  out  1  one-cycle pulse when the transfer completes
serial_clock  out  1  chain shift clock
serial_data  out  1  chain data, MSB first
serial_load  out  1  chain latch strobe

Behaviour:
- Reset (async assert, sync release): state IDLE; busy, done, serial_clock, serial_data and serial_load all 0; cfg_addr = NUM_GPIO-1; shift register and counters cleared.
- Reset asserted mid-transfer aborts immediately. Outputs go to their reset values in the same cycle. No serial_load is issued, so pads keep their previously latched words.
- IDLE: start=1 at clock edge N moves the block to LOAD_A, and busy=1 from edge N+1. start while busy=1 is ignored, with no queueing.
- LOAD_A (1 cycle): cfg_addr holds the current index. The first word is pad NUM_GPIO-1, and the index decrements down to 0, so pad 0 is shifted last and ends nearest the transmitter.
- LOAD_B (1 cycle): captures cfg_data into the shift register, loads bit counter = GPIO_BITS-1, and drives serial_data = word MSB.
- SHIFT_LO (CLK_DIV cycles): serial_clock=0 and serial_data is stable. Go to SHIFT_HI.
- SHIFT_HI (CLK_DIV cycles): serial_clock=1, which gives the receiver its rising-edge sample point. On exit:
  - if bit counter > 0: decrement it, present the next bit on serial_data (this change coincides with the falling edge) and return to SHIFT_LO;
  - else if index > 0: decrement the index and go to LOAD_A (serial_clock stays 0 through LOAD_A/LOAD_B);
  - else go to LATCH.
- LATCH (CLK_DIV cycles): serial_clock=0, serial_data=0, serial_load=1.
- SETTLE (CLK_DIV cycles): serial_load=0. On exit, done=1 for one cycle, busy=0, go to IDLE, and restore cfg_addr to NUM_GPIO-1.
- Exactly NUM_GPIO*GPIO_BITS rising edges of serial_clock occur per transfer, and no serial_clock edge occurs while serial_load=1.
- Busy duration is NUM_GPIO*(2+2*CLK_DIV*GPIO_BITS)+2*CLK_DIV cycles. done is asserted in the first cycle with busy=0.
- Phase counter width is $clog2(CLK_DIV+1). Bit counter width is $clog2(GPIO_BITS). There is no wrap of the index past 0.
- start coinciding with done: ignored, because busy is still 1 on that edge. A new start is accepted the cycle after done.
- All outputs are registered, with no combinational path from start or cfg_data to any output.

Decomposition:
- Shared package gpio_cfg_pkg holds:
  - GPIO_BITS;
  - the state enum (IDLE, LOAD_A, LOAD_B, SHIFT_LO, SHIFT_HI, LATCH, SETTLE);
  - named pad-mode constants used by the defaults and config store.
- One sub-module: gpio_serial_tick, the CLK_DIV phase counter producing a phase_end pulse. It is cleared on every state change.

Test Plan:
- NUM_GPIO=2, CLK_DIV=1, store[1]=0x1803, store[0]=0x0403; pulse start -> serial_data sampled at serial_clock rises equals 1100000000011 then 0010000000011; exactly 26 rises; serial_load high 1 cycle after the last fall; busy high 58 cycles; done pulses once.
- CLK_DIV=4, default params -> each serial_clock low/high phase is exactly 4 cycles; 247 rises; cfg_addr sequence 18 down to 0; busy duration 19*106+8=2022 cycles.
- start pulsed again at cycle 10 and on the done cycle -> ignored; transfer length unchanged; second start one cycle after done accepted, busy rises next edge.
- wb_rst_i asserted for 1 cycle mid-shift of word 1 -> same-cycle serial_clock/serial_data/busy=0; no serial_load pulse; cfg_addr=NUM_GPIO-1; next start gives a full clean transfer.
- cfg_data changed after the LOAD_B capture cycle -> shifted bits reflect the captured value only.
- Store all-ones (0x1FFF) and all-zeros -> serial_data constant 1 (respectively 0) across all shift phases, returning to 0 in LATCH.
